// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage and the IF/ID register, also used by the decode stage.
package if_stage_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned PC_STEP      = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  // IF/ID field widths
  localparam int unsigned IFID_INSTR_W = INSTR_W;
  localparam int unsigned IFID_PC_W    = 32;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble clears it, hold freezes it, load captures a new instruction.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = IFID_PC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    hold,
  input  logic                    bubble,
  input  logic [IFID_INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]       pc_in,
  input  logic [ADDR_W-1:0]       pc_plus4_in,
  output logic [IFID_INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]       ifid_pc,
  output logic [ADDR_W-1:0]       ifid_pc_plus4,
  output logic                    ifid_valid
);

  // A bubble always carries NOP_INSTR so that valid=0 implies instr=0.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (load && !hold) begin
      ifid_instr    <= instr_in;
      ifid_pc       <= pc_in;
      ifid_pc_plus4 <= pc_plus4_in;
      ifid_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, halt detection and the IF/ID register.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/stall counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       IMEM_BYTES = 128,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_plus4,
  output logic               ifid_valid,
  output logic               fetch_done
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalls
`endif
);

  localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(IMEM_BYTES - PC_STEP);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
  logic              halted, load, hold, bubble;

  assign pc_plus4  = pc_q + ADDR_W'(PC_STEP);
  assign halted    = pc_q > LastPc;
  assign imem_addr = pc_q;
  assign fetch_done = halted;

  // Redirect outranks stall; stall outranks the halted bubble.
  assign bubble = redirect || (!stall && halted);
  assign hold   = stall && !redirect;
  assign load   = !stall && !redirect && !halted;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (load) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .hold          (hold),
    .bubble        (bubble),
    .instr_in      (imem_rdata),
    .pc_in         (pc_q),
    .pc_plus4_in   (pc_plus4),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (load && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (hold && (perf_stalls != '1)) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus queues per-edge expectations, a monitor checks them.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
  logic        ifid_valid, fetch_done;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stalls;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        done;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'd0:   word = 32'h0022_1820;
      32'd4:   word = 32'h0064_2022;
      32'd8:   word = 32'h00A6_2824;
      32'd12:  word = 32'h00E8_3025;
      default: word = 32'hA500_0000 | a;
    endcase
  endfunction

  assign imem_rdata = word(imem_addr);

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .fetch_done    (fetch_done)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drive inputs on the falling edge; expectation describes outputs after the next rising edge.
  task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                     input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                     input logic ed, input logic [31:0] ea);
    exp_t e;
    @(negedge clk);
    rst = r;
    stall = s;
    redirect = rd;
    redirect_pc = rpc;
    e.instr = ei;
    e.pc    = ep;
    e.pc4   = ev ? ep + 32'd4 : 32'd0;
    e.valid = ev;
    e.done  = ed;
    e.addr  = ea;
    sb.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] p);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, word(p), p, 1'b1, p == 32'd124, p + 32'd4);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ifid_instr", ifid_instr, e.instr);
      chk("ifid_pc", ifid_pc, e.pc);
      chk("ifid_pc_plus4", ifid_pc_plus4, e.pc4);
      chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
      chk("fetch_done", {31'b0, fetch_done}, {31'b0, e.done});
      chk("imem_addr", imem_addr, e.addr);
    end
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;

    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    fetch(32'd0);
    fetch(32'd4);
    // Stall two cycles with ifid_pc=4
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0064_2022, 32'd4, 1'b1, 1'b0, 32'd8);
    fetch(32'd8);
    fetch(32'd12);
    // Redirect wins over stall; target low bits dropped
    cyc(1'b0, 1'b1, 1'b1, 32'h2E, 32'h0, 32'h0, 1'b0, 1'b0, 32'h2C);
    for (int p = 32'h2C; p <= 32'h7C; p += 4) fetch(32'(p));
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd128);
    cyc(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    // Redirect beyond memory halts at once
    cyc(1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200);
    cyc(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int p = 0; p <= 32'h40; p += 4) fetch(32'(p));
    // Reset during stall and redirect
    cyc(1'b1, 1'b1, 1'b1, 32'h50, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    fetch(32'd0);

`ifdef IF_PERF_CNT_EN
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int p = 0; p < 40; p += 4) fetch(32'(p));
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0, word(32'd36), 32'd36, 1'b1, 1'b0, 32'd40);
    @(negedge clk);
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_stalls", perf_stalls, 32'd3);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_stalls_rst", perf_stalls, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
